// File: rtl/byte_seq_data_ram.sv
// -----------------------------------------------------------------------------
// byte_seq_data_ram
//
// Word-wide request interface in front of a byte-wide storage array. Each
// accepted word transaction is carried out one byte per clock through a
// single narrow port, so a legal access takes BYTES_PER_WORD clocks in XFER
// plus one clock in DONE before the next request can be accepted.
// Requests whose last byte would lie outside the array are rejected without
// touching memory or read_data and complete with err=1.
//
// Ports
//   clk            in   clock, all state changes on rising edge
//   rst_n          in   asynchronous active-low reset
//   req            in   transaction request, sampled only in IDLE
//   read_not_write in   1 = read, 0 = write, sampled with req
//   address        in   byte address of word byte 0, sampled with req
//   write_data     in   write word, little-endian lanes, sampled with req
//   byte_en        in   per-byte write enable, sampled with req, unused on reads
//   read_data      out  last completed read word (lanes fill progressively)
//   ack            out  one-cycle completion pulse (registered)
//   err            out  out-of-range flag, valid only while ack is high
//   busy           out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module byte_seq_data_ram #(
   parameter int BYTES_PER_WORD = 3,
   parameter int ADDR_WIDTH     = 8,
   parameter int DEPTH_BYTES    = 128
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        req,
   input  logic                        read_not_write,
   input  logic [ADDR_WIDTH-1:0]       address,
   input  logic [8*BYTES_PER_WORD-1:0] write_data,
   input  logic [BYTES_PER_WORD-1:0]   byte_en,
   output logic [8*BYTES_PER_WORD-1:0] read_data,
   output logic                        ack,
   output logic                        err,
   output logic                        busy
);

   localparam int W     = 8 * BYTES_PER_WORD;
   localparam int CNT_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
   localparam int IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

   localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(BYTES_PER_WORD - 1);
   localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
   // Range check runs one bit wider than the address so it cannot wrap.
   localparam logic [ADDR_WIDTH:0] SPAN      = (ADDR_WIDTH + 1)'(BYTES_PER_WORD - 1);
   localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH_BYTES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    rnw_q, rnw_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [W-1:0]            wdata_q, wdata_d;
   logic [BYTES_PER_WORD-1:0] be_q, be_d;
   logic [W-1:0]            rdata_q, rdata_d;
   logic                    ack_q, ack_d;
   logic                    err_q, err_d;
   logic                    range_err_q, range_err_d;

   logic [7:0]              mem_q [0:DEPTH_BYTES-1];

   logic [ADDR_WIDTH-1:0]   byte_addr_s;
   logic [IDX_W-1:0]        byte_idx_s;
   logic [7:0]              wr_byte_s;
   logic                    mem_we_s;
   logic                    range_bad_s;

   // Byte currently addressed in XFER; legal requests never exceed the array,
   // so truncating to the array index width loses nothing.
   assign byte_addr_s = addr_q + ADDR_WIDTH'(cnt_q);
   assign byte_idx_s  = byte_addr_s[IDX_W-1:0];
   assign wr_byte_s   = wdata_q[{cnt_q, 3'b000} +: 8];
   assign range_bad_s = (({1'b0, address} + SPAN) >= DEPTH_EXT) ? 1'b1 : 1'b0;

   assign read_data = rdata_q;
   assign ack       = ack_q;
   assign err       = err_q;
   assign busy      = (state_q != IDLE) ? 1'b1 : 1'b0;

   // Next-state, request capture, lane update and completion decode.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rnw_d       = rnw_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      rdata_d     = rdata_q;
      range_err_d = range_err_q;
      ack_d       = 1'b0;
      err_d       = 1'b0;
      mem_we_s    = 1'b0;

      case (state_q)
         IDLE: begin
            if (req) begin
               rnw_d   = read_not_write;
               addr_d  = address;
               wdata_d = write_data;
               be_d    = byte_en;
               cnt_d   = {CNT_W{1'b0}};
               if (range_bad_s) begin
                  range_err_d = 1'b1;
                  state_d     = DONE;
               end else begin
                  range_err_d = 1'b0;
                  state_d     = XFER;
               end
            end else begin
               state_d = IDLE;
            end
         end

         XFER: begin
            if (rnw_q) begin
               rdata_d[{cnt_q, 3'b000} +: 8] = mem_q[byte_idx_s];
            end else begin
               mem_we_s = be_q[cnt_q];
            end
            if (cnt_q == CNT_LAST) begin
               // Legal completion: ack rises on the edge that enters DONE.
               state_d = DONE;
               cnt_d   = {CNT_W{1'b0}};
               ack_d   = 1'b1;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end

         DONE: begin
            state_d = IDLE;
            // Rejected request: ack/err rise on the edge that leaves DONE,
            // one edge after acceptance.
            if (range_err_q) begin
               ack_d = 1'b1;
               err_d = 1'b1;
            end else begin
               ack_d = 1'b0;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
   end

   // Control, capture and output registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= {CNT_W{1'b0}};
         rnw_q       <= 1'b0;
         addr_q      <= {ADDR_WIDTH{1'b0}};
         wdata_q     <= {W{1'b0}};
         be_q        <= {BYTES_PER_WORD{1'b0}};
         rdata_q     <= {W{1'b0}};
         ack_q       <= 1'b0;
         err_q       <= 1'b0;
         range_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rnw_q       <= rnw_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         rdata_q     <= rdata_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
         range_err_q <= range_err_d;
      end
   end

   // Byte storage; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[byte_idx_s] <= wr_byte_s;
      end
   end

endmodule

// File: tb/tb_byte_seq_data_ram.sv
// -----------------------------------------------------------------------------
// tb_byte_seq_data_ram
//
// Directed bench for byte_seq_data_ram. One instance uses the default
// 3-byte word, a second uses a 4-byte word. Expected values are written out
// by hand next to each stimulus.
// -----------------------------------------------------------------------------
module tb_byte_seq_data_ram;

   logic        clk;
   logic        rst_n;
   logic        req3, req4;
   logic        rnw;
   logic [7:0]  addr;
   logic [31:0] wdata;
   logic [3:0]  ben;

   logic [23:0] rdata3;
   logic        ack3, err3, busy3;
   logic [31:0] rdata4;
   logic        ack4, err4, busy4;

   int n_checks;
   int n_errors;

   byte_seq_data_ram #(
      .BYTES_PER_WORD(3), .ADDR_WIDTH(8), .DEPTH_BYTES(128)
   ) dut3 (
      .clk(clk), .rst_n(rst_n), .req(req3), .read_not_write(rnw),
      .address(addr), .write_data(wdata[23:0]), .byte_en(ben[2:0]),
      .read_data(rdata3), .ack(ack3), .err(err3), .busy(busy3)
   );

   byte_seq_data_ram #(
      .BYTES_PER_WORD(4), .ADDR_WIDTH(8), .DEPTH_BYTES(128)
   ) dut4 (
      .clk(clk), .rst_n(rst_n), .req(req4), .read_not_write(rnw),
      .address(addr), .write_data(wdata), .byte_en(ben),
      .read_data(rdata4), .ack(ack4), .err(err4), .busy(busy4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // Issue one transaction from #1 after a rising edge; returns read_data and
   // err sampled while ack is high, plus edges from acceptance to ack.
   task automatic run_txn(input string tag, input bit sel4, input bit r,
                          input logic [7:0] a, input logic [31:0] wd,
                          input logic [3:0] be, output logic [31:0] rd,
                          output logic e, output int lat);
      bit got;
      check_eq({tag, "_idle"}, {31'd0, sel4 ? busy4 : busy3}, 32'd0);
      rnw   = r;
      addr  = a;
      wdata = wd;
      ben   = be;
      if (sel4) req4 = 1'b1; else req3 = 1'b1;
      @(posedge clk);
      #1;
      req3 = 1'b0;
      req4 = 1'b0;
      lat  = 0;
      got  = 1'b0;
      while (!got && lat < 12) begin
         @(posedge clk);
         #1;
         lat++;
         if ((sel4 ? ack4 : ack3) == 1'b1) got = 1'b1;
      end
      check_eq({tag, "_ack_seen"}, {31'd0, got}, 32'd1);
      rd = sel4 ? rdata4 : {8'h00, rdata3};
      e  = sel4 ? err4 : err3;
      @(posedge clk);
      #1;
      check_eq({tag, "_ack_pulse"}, {31'd0, sel4 ? ack4 : ack3}, 32'd0);
   endtask

   logic [31:0] rd;
   logic        e;
   int          lat;

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      req3  = 1'b0;
      req4  = 1'b0;
      rnw   = 1'b0;
      addr  = 8'h00;
      wdata = 32'h0;
      ben   = 4'h0;

      // Reset state
      #2;
      check_eq("rst_ack",   {31'd0, ack3},  32'd0);
      check_eq("rst_err",   {31'd0, err3},  32'd0);
      check_eq("rst_busy",  {31'd0, busy3}, 32'd0);
      check_eq("rst_rdata", {8'h00, rdata3}, 32'd0);
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic write then read of 0x10
      run_txn("w10", 1'b0, 1'b0, 8'h10, 32'h000014, 4'b0111, rd, e, lat);
      check_eq("w10_lat", lat, 32'd3);
      check_eq("w10_err", {31'd0, e}, 32'd0);
      run_txn("r10", 1'b0, 1'b1, 8'h10, 32'h0, 4'b0000, rd, e, lat);
      check_eq("r10_lat", lat, 32'd3);
      check_eq("r10_err", {31'd0, e}, 32'd0);
      check_eq("r10_data", rd, 32'h000014);

      // Byte-enable merge at 0x20
      run_txn("w20a", 1'b0, 1'b0, 8'h20, 32'h112233, 4'b0111, rd, e, lat);
      run_txn("w20b", 1'b0, 1'b0, 8'h20, 32'hAABBCC, 4'b0101, rd, e, lat);
      check_eq("w20b_rdata_kept", {8'h00, rdata3}, 32'h000014);
      run_txn("r20", 1'b0, 1'b1, 8'h20, 32'h0, 4'b0000, rd, e, lat);
      check_eq("r20_data", rd, 32'hAA22CC);
      // All-zero byte_en write: full length, no memory change
      run_txn("w20z", 1'b0, 1'b0, 8'h20, 32'hFFFFFF, 4'b0000, rd, e, lat);
      check_eq("w20z_lat", lat, 32'd3);
      check_eq("w20z_rdata_kept", {8'h00, rdata3}, 32'hAA22CC);
      run_txn("r20z", 1'b0, 1'b1, 8'h20, 32'h0, 4'b0000, rd, e, lat);
      check_eq("r20z_data", rd, 32'hAA22CC);

      // Range edges
      run_txn("w7d", 1'b0, 1'b0, 8'h7D, 32'h445566, 4'b0111, rd, e, lat);
      check_eq("w7d_err", {31'd0, e}, 32'd0);
      run_txn("r7d", 1'b0, 1'b1, 8'h7D, 32'h0, 4'b0000, rd, e, lat);
      check_eq("r7d_err", {31'd0, e}, 32'd0);
      check_eq("r7d_data", rd, 32'h445566);
      run_txn("r7e", 1'b0, 1'b1, 8'h7E, 32'h0, 4'b0000, rd, e, lat);
      check_eq("r7e_lat", lat, 32'd1);
      check_eq("r7e_err", {31'd0, e}, 32'd1);
      check_eq("r7e_data_kept", rd, 32'h445566);
      run_txn("w7e", 1'b0, 1'b0, 8'h7E, 32'h999999, 4'b0111, rd, e, lat);
      check_eq("w7e_lat", lat, 32'd1);
      check_eq("w7e_err", {31'd0, e}, 32'd1);
      run_txn("rff", 1'b0, 1'b1, 8'hFF, 32'h0, 4'b0000, rd, e, lat);
      check_eq("rff_err", {31'd0, e}, 32'd1);
      run_txn("r7d2", 1'b0, 1'b1, 8'h7D, 32'h0, 4'b0000, rd, e, lat);
      check_eq("r7d2_data", rd, 32'h445566);

      // req held high for three reads of 0x10
      begin
         int acc_cyc [3];
         int n_acc, n_ack, n_low, cyc;
         logic prev_busy;
         n_acc = 0; n_ack = 0; n_low = 0; cyc = 0;
         prev_busy = busy3;
         rnw  = 1'b1;
         addr = 8'h10;
         ben  = 4'b0000;
         req3 = 1'b1;
         while (n_ack < 3 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy3 && !prev_busy) begin
               if (n_acc < 3) acc_cyc[n_acc] = cyc;
               n_acc++;
               if (n_acc == 3) req3 = 1'b0;
            end
            if (!busy3 && n_acc >= 1 && n_acc < 3) n_low++;
            if (ack3) begin
               n_ack++;
               check_eq("hold_data", {8'h00, rdata3}, 32'h000014);
            end
            prev_busy = busy3;
         end
         req3 = 1'b0;
         check_eq("hold_acks", n_ack, 32'd3);
         check_eq("hold_accepts", n_acc, 32'd3);
         check_eq("hold_gap1", acc_cyc[1] - acc_cyc[0], 32'd5);
         check_eq("hold_gap2", acc_cyc[2] - acc_cyc[1], 32'd5);
         check_eq("hold_busy_low", n_low, 32'd2);
         @(posedge clk);
         #1;
      end

      // Reset mid-XFER
      run_txn("w30z", 1'b0, 1'b0, 8'h30, 32'h000000, 4'b0111, rd, e, lat);
      begin
         int n_ack;
         rnw   = 1'b0;
         addr  = 8'h30;
         wdata = 32'hCCBBAA;
         ben   = 4'b0111;
         req3  = 1'b1;
         @(posedge clk);
         #1;
         req3 = 1'b0;
         @(posedge clk);
         #1;
         rst_n = 1'b0;
         #1;
         check_eq("abort_busy",  {31'd0, busy3}, 32'd0);
         check_eq("abort_ack",   {31'd0, ack3},  32'd0);
         check_eq("abort_rdata", {8'h00, rdata3}, 32'd0);
         #2 rst_n = 1'b1;
         n_ack = 0;
         repeat (6) begin
            @(posedge clk);
            #1;
            if (ack3) n_ack++;
         end
         check_eq("abort_no_ack", n_ack, 32'd0);
      end
      run_txn("r30", 1'b0, 1'b1, 8'h30, 32'h0, 4'b0000, rd, e, lat);
      check_eq("r30_data", rd, 32'h0000AA);

      // 4-byte word instance
      run_txn("w4", 1'b1, 1'b0, 8'h10, 32'h01020304, 4'b1111, rd, e, lat);
      check_eq("w4_lat", lat, 32'd4);
      check_eq("w4_err", {31'd0, e}, 32'd0);
      run_txn("r4", 1'b1, 1'b1, 8'h10, 32'h0, 4'b0000, rd, e, lat);
      check_eq("r4_lat", lat, 32'd4);
      check_eq("r4_data", rd, 32'h01020304);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
